instr_encoder: RTL and testbench

- Encoder counterpart of the control decoder. Accepts instruction fields (Cond, Op, Funct, Rd, Rn, Src2, Imm24) over a valid/ready stream and packs each one into a 32-bit instruction word in the same layout the decoder splits apart.
- Writes each packed word into instruction memory at sequential word addresses.
- Used to load programs into the single-cycle processor's instruction memory for self-checking benches and boot loading.

---
 rtl/instr_encoder.sv | 145 ++++++++++++++
 tb/tb_instr_encoder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Packs instruction field bundles into 32-bit words and writes them to instruction memory at sequential addresses.
// Two cycles per word (accept, write); in_ready drops during the write cycle, on start, and once memory is full.
module instr_encoder #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        Cond,
    input  logic [1:0]        Op,
    input  logic [5:0]        Funct,
    input  logic [3:0]        Rn,
    input  logic [3:0]        Rd,
    input  logic [11:0]       Src2,
    input  logic [23:0]       Imm24,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCEPT,
        S_WRITE,
        S_FULL
    } state_t;

    localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};

    state_t              state;
    state_t              next_state;
    logic [ADDR_W-1:0]   ptr;
    logic [ADDR_W:0]     count_inc;
    logic [31:0]         packed_word;
    logic                take_legal;
    logic                take_illegal;
    logic                clear;

    // Branch format keeps only the two high Funct bits; the rest of the word is the immediate.
    always_comb begin
        if (Op == 2'b10) begin
            packed_word = {Cond, Op, Funct[5:4], Imm24};
        end else begin
            packed_word = {Cond, Op, Funct, Rn, Rd, Src2};
        end
    end

    assign count_inc = count + (ADDR_W+1)'(1);

    always_comb begin
        next_state   = state;
        in_ready     = 1'b0;
        mem_we       = 1'b0;
        take_legal   = 1'b0;
        take_illegal = 1'b0;
        clear        = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    next_state = S_ACCEPT;
                    clear      = 1'b1;
                end
            end
            S_ACCEPT: begin
                if (start) begin
                    clear = 1'b1;
                end else begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        if (Op == 2'b11) begin
                            take_illegal = 1'b1;
                        end else begin
                            take_legal = 1'b1;
                            next_state = S_WRITE;
                        end
                    end
                end
            end
            S_WRITE: begin
                // The pending write always completes; a start only clears state afterwards.
                mem_we = 1'b1;
                if (start) begin
                    next_state = S_ACCEPT;
                    clear      = 1'b1;
                end else if (count_inc == CAPACITY) begin
                    next_state = S_FULL;
                end else begin
                    next_state = S_ACCEPT;
                end
            end
            S_FULL: begin
                if (start) begin
                    next_state = S_ACCEPT;
                    clear      = 1'b1;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
        if (reset) begin
            in_ready = 1'b0;
            mem_we   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            ptr       <= '0;
            count     <= '0;
            full      <= 1'b0;
            err       <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state <= next_state;
            full  <= (next_state == S_FULL);
            if (clear) begin
                ptr   <= '0;
                count <= '0;
                err   <= 1'b0;
            end else begin
                if (state == S_WRITE) begin
                    ptr   <= ptr + ADDR_W'(1);
                    count <= count_inc;
                end
                if (take_illegal) begin
                    err <= 1'b1;
                end
            end
            // Address/data are captured at the handshake so they hold steady between writes.
            if (take_legal) begin
                mem_addr  <= ptr;
                mem_wdata <= packed_word;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder with a 4-word memory so the full boundary is reachable quickly.
module tb_instr_encoder;

    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          reset, start, in_valid, in_ready;
    logic [3:0]    Cond, Rn, Rd;
    logic [1:0]    Op;
    logic [5:0]    Funct;
    logic [11:0]   Src2;
    logic [23:0]   Imm24;
    logic          mem_we, full, err;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [AW:0]   count;

    int total = 0;
    int bad = 0;
    int we_total = 0;
    int w0;
    logic [31:0] wq_addr[$];
    logic [31:0] wq_data[$];

    instr_encoder #(.ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .Cond(Cond), .Op(Op), .Funct(Funct), .Rn(Rn), .Rd(Rd), .Src2(Src2), .Imm24(Imm24),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .count(count), .full(full), .err(err)
    );

    always #5 clk = ~clk;

    // Log what the memory sees just before each rising edge.
    always begin
        @(negedge clk);
        #3;
        if (mem_we) begin
            we_total++;
            wq_addr.push_back(32'(mem_addr));
            wq_data.push_back(mem_wdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic set_fields(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                              input logic [3:0] n, input logic [3:0] d, input logic [11:0] s,
                              input logic [23:0] imm);
        Cond = c; Op = o; Funct = f; Rn = n; Rd = d; Src2 = s; Imm24 = imm;
    endtask

    task automatic send(input string tag, input logic [3:0] c, input logic [1:0] o,
                        input logic [5:0] f, input logic [3:0] n, input logic [3:0] d,
                        input logic [11:0] s, input logic [23:0] imm,
                        input logic exp_we, input logic [31:0] exp_addr, input logic [31:0] exp_data);
        int n_wait;
        set_fields(c, o, f, n, d, s, imm);
        in_valid = 1'b1;
        #1;
        n_wait = 0;
        while (!in_ready && n_wait < 20) begin
            cyc();
            n_wait++;
        end
        if (!in_ready) chk({tag, "_rdy_timeout"}, 32'(in_ready), 32'd1);
        cyc();
        in_valid = 1'b0;
        chk({tag, "_we"}, 32'(mem_we), 32'(exp_we));
        chk({tag, "_addr"}, 32'(mem_addr), exp_addr);
        chk({tag, "_data"}, mem_wdata, exp_data);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rdy"}, 32'(in_ready), 32'd0);
        chk({tag, "_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_data"}, mem_wdata, 32'd0);
        chk({tag, "_count"}, 32'(count), 32'd0);
        chk({tag, "_full"}, 32'(full), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0;
        set_fields(4'h0, 2'b00, 6'h00, 4'h0, 4'h0, 12'h000, 24'h0);
        repeat (3) cyc();
        chk_reset_vals("rst");
        reset = 1'b0;

        in_valid = 1'b1;
        cyc();
        chk("idle_rdy", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        cyc();
        chk("idle_we", 32'(we_total), 32'd0);

        start = 1'b1;
        #1 chk("start_rdy", 32'(in_ready), 32'd0);
        cyc();
        start = 1'b0;
        #1 chk("accept_rdy", 32'(in_ready), 32'd1);

        send("add", 4'hE, 2'b00, 6'b101000, 4'h1, 4'h2, 12'h005, 24'h0, 1'b1, 0, 32'hE2812005);
        cyc();
        chk("add_count", 32'(count), 32'd1);
        chk("add_rdy", 32'(in_ready), 32'd1);

        send("ldr", 4'hE, 2'b01, 6'b011001, 4'h0, 4'h3, 12'h004, 24'h0, 1'b1, 1, 32'hE5903004);
        send("b", 4'h0, 2'b10, 6'b100000, 4'h7, 4'h7, 12'h777, 24'hFFFFFE, 1'b1, 2, 32'h0AFFFFFE);
        cyc();
        chk("b_count", 32'(count), 32'd3);

        send("ill", 4'hE, 2'b11, 6'h3F, 4'h1, 4'h1, 12'h001, 24'h0, 1'b0, 2, 32'h0AFFFFFE);
        chk("ill_err", 32'(err), 32'd1);
        chk("ill_count", 32'(count), 32'd3);
        chk("ill_rdy", 32'(in_ready), 32'd1);
        send("after_ill", 4'hE, 2'b00, 6'b000100, 4'h1, 4'h1, 12'h001, 24'h0, 1'b1, 3, 32'hE0411001);
        cyc();
        chk("full_count", 32'(count), 32'd4);
        chk("full_flag", 32'(full), 32'd1);
        chk("full_err", 32'(err), 32'd1);
        chk("full_rdy", 32'(in_ready), 32'd0);

        w0 = we_total;
        in_valid = 1'b1;
        repeat (4) cyc();
        chk("full_hold_rdy", 32'(in_ready), 32'd0);
        chk("full_hold_we", 32'(we_total), 32'(w0));
        in_valid = 1'b0;

        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("restart_full", 32'(full), 32'd0);
        chk("restart_count", 32'(count), 32'd0);
        chk("restart_err", 32'(err), 32'd0);

        // Continuous in_valid: one word per two cycles until the 4-word memory fills.
        wq_addr.delete();
        wq_data.delete();
        w0 = we_total;
        set_fields(4'h0, 2'b10, 6'b100000, 4'h0, 4'h0, 12'h000, 24'h123456);
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1 chk($sformatf("stream_rdy%0d", i), 32'(in_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
            cyc();
        end
        repeat (3) cyc();
        chk("stream_rdy_full", 32'(in_ready), 32'd0);
        chk("stream_full", 32'(full), 32'd1);
        chk("stream_count", 32'(count), 32'd4);
        chk("stream_nwr", 32'(we_total - w0), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (wq_addr.size() > i) begin
                chk($sformatf("stream_addr%0d", i), wq_addr[i], 32'(i));
                chk($sformatf("stream_data%0d", i), wq_data[i], 32'h0A123456);
            end
        end

        start = 1'b1;
        #1 chk("restart2_rdy", 32'(in_ready), 32'd0);
        cyc();
        start = 1'b0;
        #1 chk("restart2_rdy1", 32'(in_ready), 32'd1);
        cyc();
        chk("restart2_we", 32'(mem_we), 32'd1);
        chk("restart2_addr", 32'(mem_addr), 32'd0);
        in_valid = 1'b0;
        cyc();
        chk("restart2_count", 32'(count), 32'd1);

        // start and in_valid together while accepting: bundle waits one cycle, lands at 0.
        set_fields(4'h1, 2'b00, 6'h00, 4'h0, 4'h0, 12'hABC, 24'h0);
        start = 1'b1;
        in_valid = 1'b1;
        #1 chk("prio_rdy", 32'(in_ready), 32'd0);
        cyc();
        start = 1'b0;
        #1 chk("prio_rdy1", 32'(in_ready), 32'd1);
        cyc();
        chk("prio_we", 32'(mem_we), 32'd1);
        chk("prio_addr", 32'(mem_addr), 32'd0);
        chk("prio_data", mem_wdata, 32'h10000ABC);
        in_valid = 1'b0;
        cyc();
        chk("prio_count", 32'(count), 32'd1);

        send("pre_rst", 4'hF, 2'b01, 6'h3F, 4'hF, 4'hF, 12'hFFF, 24'h0, 1'b1, 1, 32'hF7FFFFFF);
        reset = 1'b1;
        #1;
        chk("rst_write_we", 32'(mem_we), 32'd0);
        chk("rst_write_rdy", 32'(in_ready), 32'd0);
        w0 = we_total;
        cyc();
        reset = 1'b0;
        chk_reset_vals("rst_write");
        in_valid = 1'b1;
        repeat (3) cyc();
        chk("post_rst_rdy", 32'(in_ready), 32'd0);
        chk("post_rst_we", 32'(we_total), 32'(w0));
        in_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: bench did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
